conv_scheduler: RTL and testbench
=================================

Name: conv_scheduler

Overview:
- Measurement scheduler for the multi-slope converter, clocked at clk1ms.
- Selects the front-end input mux (signal / zero / reference) and waits a settling time.
- Commands one integrate-rundown conversion per channel slot and collects the raw count.
- Presents an offset-corrected result to the host on a valid/ready handshake, plus sticky error flags.

Parameters:
RES_W, 24, width of raw conversion result from converter engine
SETTLE, 5, clk1ms cycles of mux settling before each conversion start (>=1)
ZERO_EVERY, 4, number of input conversions between auto-zero conversions (>=1)
TIMEOUT, 1023, max clk1ms cycles from conv_start to conv_done before abort

Ports:
clk1ms  in  1  1 ms system tick clock
rst  in  1  asynchronous, active-high reset
en  in  1  level; 1 = run continuous scheduled conversions
npl_cfg  in  10  integration length in power-line cycles for every conversion
clear_err  in  1  one-cycle pulse, clears sticky flags
conv_start  out  1  one-cycle pulse to converter engine
conv_npl  out  10  integration length to engine, stable from SEL until conv_done
conv_done  in  1  one-cycle pulse from engine, conv_result valid same cycle
conv_result  in  RES_W  raw signed count
mux_sel  out  2  0=input, 1=zero, 2=reference
out_valid  out  1  result available
out_ready  in  1  host accepts result
out_data  out  RES_W+1  signed input minus latest zero
ref_data  out  RES_W  latest reference raw count (see Optional Feature)
err_timeout  out  1  sticky
err_overrun  out  1  sticky

Behaviour:
- Reset values: conv_start=0, conv_npl=0, mux_sel=0, out_valid=0, out_data=0, ref_data=0, err flags=0, zero_reg=0, az_cnt=0, zero_due=1, state=IDLE.
- States: IDLE, SEL, SETTLE, START, WAIT, STORE.
- IDLE: when en=1, choose the next channel and go to SEL.
  - Channel is zero if zero_due=1.
  - Otherwise the channel is reference if ref_due=1 (feature only).
  - Otherwise the channel is input.
- SEL (1 cycle): drive mux_sel, latch npl_cfg into conv_npl, clear the settle counter.
- SETTLE: exactly SETTLE cycles, then START.
- START (1 cycle): conv_start=1, clear the timeout counter, go to WAIT.
- WAIT: hold until conv_done.
  - Timeout counter reaches TIMEOUT without conv_done: set err_timeout, go to IDLE, store nothing, keep channel due state so the same channel retries.
  - conv_done arriving in the same cycle as the limit counts as done.
- STORE (1 cycle), zero channel: zero_reg<=conv_result, zero_due<=0, az_cnt<=0.
- STORE, input channel:
  - out_data<=sign-extended conv_result minus sign-extended zero_reg, full RES_W+1 width, no saturation.
  - out_valid<=1.
  - az_cnt increments; when it reaches ZERO_EVERY, zero_due<=1.
- After STORE, return to IDLE.
- en is sampled only in IDLE. Deasserting en mid-cycle finishes the current conversion and store, then idles.
- Each rising edge of en (IDLE with en 0→1) forces zero_due=1.
- Sequence with ZERO_EVERY=4 and feature off: Z,I,I,I,I,Z,I,...
- Output handshake:
  - The transfer happens on out_valid & out_ready.
  - out_valid stays high until that transfer.
  - If an input STORE occurs while out_valid=1 and out_ready=0, out_data is overwritten and err_overrun is set.
  - If an input STORE and out_ready occur in the same cycle, the old value transfers, the new value loads, out_valid stays 1, and there is no overrun.
- Sticky flags: clear_err clears both flags. A flag-setting event in the same cycle as clear_err wins, so the flag ends at 1.
- Reset mid-operation returns everything to reset values immediately. conv_start is never glitched.

Optional Feature:
- Macro: REF_CAL_EN.
- Defined:
  - The reference channel is scheduled immediately after every zero conversion (Z,R,I,I,I,I,Z,R,...).
  - STORE for the reference channel sets ref_data<=conv_result and ref_due<=0.
  - ref_due is set together with zero_due.
- Undefined:
  - The reference channel is never selected and mux_sel never equals 2.
  - ref_data is tied to 0 and the ref_due logic is absent.

Test Plan:
- Reset, then en=1, npl_cfg=3, ZERO_EVERY=4; engine returns done 60 cycles after start, result 100 for zero and 1100 for input → mux order 1,0,0,0,0,1; conv_start occurs exactly SETTLE+2 cycles after leaving IDLE; each out_data=1000.
- zero result=500, input=-200 → out_data=-700 (RES_W+1 signed).
- Engine never asserts done → err_timeout=1 at exactly TIMEOUT cycles after conv_start; the zero conversion is retried next; clear_err clears the flag.
- out_ready held 0 across two input results → second value visible, err_overrun=1. out_ready=1 in the same cycle as a STORE → no overrun, out_valid stays 1.
- en dropped during WAIT → the conversion completes, one out_valid is produced, the block then idles. Raising en again → a zero conversion comes first.
- With REF_CAL_EN defined, reference result 7777 → mux order 1,2,0,...; ref_data=7777. Assert rst during WAIT → all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/conv_scheduler.sv
// Measurement scheduler for the multi-slope converter: mux select, settle, convert, offset-correct.
// Optional reference-calibration channel enabled by defining REF_CAL_EN.
module conv_scheduler #(
  parameter int RES_W      = 24,
  parameter int SETTLE     = 5,
  parameter int ZERO_EVERY = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic             clk1ms,
  input  logic             rst,
  input  logic             en,
  input  logic [9:0]       npl_cfg,
  input  logic             clear_err,
  output logic             conv_start,
  output logic [9:0]       conv_npl,
  input  logic             conv_done,
  input  logic [RES_W-1:0] conv_result,
  output logic [1:0]       mux_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W:0]   out_data,
  output logic [RES_W-1:0] ref_data,
  output logic             err_timeout,
  output logic             err_overrun
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = $clog2(ZERO_EVERY + 1);

  localparam logic [1:0] ChInput = 2'd0;
  localparam logic [1:0] ChZero  = 2'd1;
`ifdef REF_CAL_EN
  localparam logic [1:0] ChRef   = 2'd2;
`endif

  typedef enum logic [2:0] {StIdle, StSel, StSettle, StStart, StWait, StStore} state_t;

  state_t           state;
  logic [SW-1:0]    settle_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic [AW-1:0]    az_cnt;
  logic             zero_due;
  logic             en_prev;
  logic [RES_W-1:0] zero_reg;
  logic [RES_W-1:0] res_q;
  logic             en_rise;

  // en history only advances in IDLE, so a drop and re-raise around a conversion still counts
  assign en_rise = en & ~en_prev;

`ifdef REF_CAL_EN
  logic             ref_due;
  logic [RES_W-1:0] ref_q;
  assign ref_data = ref_q;
`else
  assign ref_data = '0;
`endif

  always_ff @(posedge clk1ms or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
      az_cnt      <= '0;
      zero_due    <= 1'b1;
      en_prev     <= 1'b0;
      zero_reg    <= '0;
      res_q       <= '0;
      conv_start  <= 1'b0;
      conv_npl    <= '0;
      mux_sel     <= ChInput;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
`ifdef REF_CAL_EN
      ref_due     <= 1'b1;
      ref_q       <= '0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      // Clear first so a same-cycle setting event below wins
      if (clear_err) begin
        err_timeout <= 1'b0;
        err_overrun <= 1'b0;
      end
      unique case (state)
        StIdle: begin
          en_prev <= en;
          if (en) begin
            conv_npl <= npl_cfg;
            state    <= StSel;
            if (zero_due || en_rise) begin
              mux_sel  <= ChZero;
              zero_due <= 1'b1;
`ifdef REF_CAL_EN
              ref_due  <= 1'b1;
`endif
            end
`ifdef REF_CAL_EN
            else if (ref_due) mux_sel <= ChRef;
`endif
            else mux_sel <= ChInput;
          end
        end
        StSel: begin
          settle_cnt <= '0;
          state      <= StSettle;
        end
        StSettle: begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            conv_start <= 1'b1;
            state      <= StStart;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        StStart: begin
          conv_start <= 1'b0;
          tmo_cnt    <= '0;
          state      <= StWait;
        end
        StWait: begin
          // A done on the limit cycle is still accepted
          if (conv_done) begin
            res_q <= conv_result;
            state <= StStore;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= StIdle;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        StStore: begin
          state <= StIdle;
          case (mux_sel)
            ChZero: begin
              zero_reg <= res_q;
              zero_due <= 1'b0;
              az_cnt   <= '0;
            end
`ifdef REF_CAL_EN
            ChRef: begin
              ref_q   <= res_q;
              ref_due <= 1'b0;
            end
`endif
            default: begin
              out_data  <= {res_q[RES_W-1], res_q} - {zero_reg[RES_W-1], zero_reg};
              out_valid <= 1'b1;
              if (out_valid && !out_ready) err_overrun <= 1'b1;
              az_cnt <= az_cnt + 1'b1;
              if (az_cnt == AW'(ZERO_EVERY - 1)) begin
                zero_due <= 1'b1;
`ifdef REF_CAL_EN
                ref_due  <= 1'b1;
`endif
              end
            end
          endcase
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_scheduler.sv
// Scoreboard bench for conv_scheduler: directed phases with a behavioural converter engine.
module tb_conv_scheduler;
  localparam int RES_W      = 24;
  localparam int SETTLE     = 5;
  localparam int ZERO_EVERY = 4;
  localparam int TIMEOUT    = 100;
`ifdef REF_CAL_EN
  localparam bit REF = 1'b1;
`else
  localparam bit REF = 1'b0;
`endif

  logic             clk1ms = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [9:0]       npl_cfg = 10'd3;
  logic             clear_err = 1'b0;
  logic             conv_done = 1'b0;
  logic [RES_W-1:0] conv_result = '0;
  logic             out_ready = 1'b0;
  logic             conv_start;
  logic [9:0]       conv_npl;
  logic [1:0]       mux_sel;
  logic             out_valid;
  logic [RES_W:0]   out_data;
  logic [RES_W-1:0] ref_data;
  logic             err_timeout;
  logic             err_overrun;

  conv_scheduler #(
    .RES_W(RES_W), .SETTLE(SETTLE), .ZERO_EVERY(ZERO_EVERY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk1ms(clk1ms), .rst(rst), .en(en), .npl_cfg(npl_cfg), .clear_err(clear_err),
    .conv_start(conv_start), .conv_npl(conv_npl), .conv_done(conv_done),
    .conv_result(conv_result), .mux_sel(mux_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .ref_data(ref_data),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk1ms = ~clk1ms;

  int cyc = 0;
  always @(posedge clk1ms) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: expected out_data values, consumed on each handshake transfer
  logic signed [63:0] sb[$];
  always @(negedge clk1ms) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_output: got %0d, expected no transfer", $signed(out_data));
      end else begin
        chk("out_data_xfer", $signed(out_data), sb.pop_front());
      end
    end
  end

  // Converter engine model
  int zval = 100, ival = 1100, istep = 0, rval = 7777, eng_delay = 60;
  bit eng_hang = 1'b0;
  int mlog[$];
  int st_cyc[$];
  int dn_cyc[$];
  int in_done = 0;

  initial begin : engine
    int sel;
    forever begin
      @(negedge clk1ms);
      if (conv_start && !rst) begin
        sel = int'(mux_sel);
        mlog.push_back(sel);
        st_cyc.push_back(cyc);
        if (!eng_hang) begin
          repeat (eng_delay) @(posedge clk1ms);
          #1;
          if (!rst) begin
            conv_done   = 1'b1;
            conv_result = (sel == 1) ? RES_W'(zval) : (sel == 2) ? RES_W'(rval) : RES_W'(ival);
            dn_cyc.push_back(cyc);
            if (sel == 0) begin
              in_done++;
              ival += istep;
            end
            @(posedge clk1ms);
            #1;
            conv_done = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk1ms);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk1ms);
  endtask

  task automatic wait_starts(input int n, input string name);
    int k = 0;
    while (mlog.size() < n && k < 5000) begin
      @(negedge clk1ms);
      k++;
    end
    chk(name, mlog.size(), n);
  endtask

  // Reference build inserts an R conversion after each Z
  function automatic void expand(input int b[$], output int e[$]);
    e = {};
    foreach (b[i]) begin
      e.push_back(b[i]);
      if (REF && b[i] == 1) e.push_back(2);
    end
  endfunction

  task automatic check_order(input int base, input int e[$], input string name);
    chk({name, "_count"}, mlog.size(), base + e.size());
    foreach (e[i]) begin
      if (base + i < mlog.size()) chk($sformatf("%s_mux%0d", name, i), mlog[base+i], e[i]);
      else chk($sformatf("%s_mux%0d_missing", name, i), -1, e[i]);
    end
  endtask

  initial begin : stim
    int e[$];
    int base, dbase, ib, c0, s, k;

    // Reset values
    idle(3);
    chk("rst_conv_start", conv_start, 0);
    chk("rst_conv_npl", conv_npl, 0);
    chk("rst_mux_sel", mux_sel, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ref_data", ref_data, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_err_overrun", err_overrun, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    idle(5);

    // Phase B: Z,I,I,I,I,Z with offset 1100-100
    repeat (4) sb.push_back(1000);
    expand('{1, 0, 0, 0, 0, 1}, e);
    base = mlog.size();
    dbase = dn_cyc.size();
    tick();
    en = 1'b1;
    c0 = cyc;
    wait_starts(base + e.size(), "B_starts");
    chk("B_conv_npl", conv_npl, 3);
    tick();
    en = 1'b0;
    idle(120);
    check_order(base, e, "B");
    chk("B_first_start_lat", st_cyc[base] - c0, SETTLE + 2);
    // done -> STORE -> IDLE -> SEL -> SETTLE x N -> START
    chk("B_restart_lat", st_cyc[base+1] - dn_cyc[dbase], SETTLE + 4);
    chk("B_sb_drained", sb.size(), 0);
`ifdef REF_CAL_EN
    chk("B_ref_data", ref_data, 7777);
`else
    chk("B_ref_data", ref_data, 0);
`endif

    // Phase C: negative result, en dropped during the input WAIT
    zval = 500;
    ival = -200;
    sb.push_back(-700);
    expand('{1, 0}, e);
    base = mlog.size();
    tick();
    en = 1'b1;
    wait_starts(base + e.size(), "C_starts");
    tick();
    en = 1'b0;
    idle(150);
    check_order(base, e, "C");
    chk("C_sb_drained", sb.size(), 0);
    chk("C_out_valid_idle", out_valid, 0);

    // Phase D: engine hangs, zero retried, done exactly on the limit cycle is accepted
    eng_hang = 1'b1;
    base = mlog.size();
    tick();
    en = 1'b1;
    wait_starts(base + 1, "D_hang_start");
    s = st_cyc[base];
    while (cyc < s + TIMEOUT) @(negedge clk1ms);
    chk("D_err_before_limit", err_timeout, 0);
    @(negedge clk1ms);
    chk("D_err_at_limit", err_timeout, 1);
    eng_hang = 1'b0;
    eng_delay = TIMEOUT;
    tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    @(negedge clk1ms);
    chk("D_err_cleared", err_timeout, 0);
    sb.push_back(-700);
    expand('{1, 1, 0}, e);
    wait_starts(base + e.size(), "D_starts");
    tick();
    en = 1'b0;
    idle(TIMEOUT + 40);
    check_order(base, e, "D");
    chk("D_no_err_on_limit_done", err_timeout, 0);
    chk("D_sb_drained", sb.size(), 0);
    eng_delay = 60;

    // Phase E: host stalls across two results -> overrun, second value visible
    zval = 100;
    ival = 1100;
    istep = 5;
    tick();
    out_ready = 1'b0;
    expand('{1, 0, 0}, e);
    base = mlog.size();
    ib = in_done;
    en = 1'b1;
    wait_starts(base + e.size(), "E_starts");
    tick();
    en = 1'b0;
    k = 0;
    while (in_done < ib + 2 && k < 2000) begin
      @(negedge clk1ms);
      k++;
    end
    idle(10);
    chk("E_out_valid", out_valid, 1);
    chk("E_out_data", out_data, 1005);
    chk("E_err_overrun", err_overrun, 1);
    sb.push_back(1005);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    idle(2);
    chk("E_valid_dropped", out_valid, 0);
    tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    @(negedge clk1ms);
    chk("E_overrun_cleared", err_overrun, 0);

    // Phase E2: ready in the STORE cycle -> old value transfers, new loads, no overrun
    sb.push_back(1010);
    expand('{1, 0, 0}, e);
    base = mlog.size();
    ib = in_done;
    tick();
    en = 1'b1;
    wait_starts(base + e.size(), "E2_starts");
    tick();
    en = 1'b0;
    k = 0;
    while (in_done < ib + 2 && k < 2000) begin
      @(negedge clk1ms);
      k++;
    end
    chk("E2_second_done_seen", in_done, ib + 2);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk1ms);
    chk("E2_out_valid", out_valid, 1);
    chk("E2_out_data", out_data, 1015);
    chk("E2_no_overrun", err_overrun, 0);
    sb.push_back(1015);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    idle(5);
    chk("E2_sb_drained", sb.size(), 0);
    istep = 0;

    // Phase G: reset asserted during WAIT clears outputs immediately
    eng_hang = 1'b1;
    base = mlog.size();
    tick();
    en = 1'b1;
    wait_starts(base + 1, "G_start");
    idle(5);
    tick();
    rst = 1'b1;
    @(negedge clk1ms);
    chk("G_conv_start", conv_start, 0);
    chk("G_conv_npl", conv_npl, 0);
    chk("G_mux_sel", mux_sel, 0);
    chk("G_out_valid", out_valid, 0);
    chk("G_out_data", out_data, 0);
    chk("G_ref_data", ref_data, 0);
    chk("G_err_timeout", err_timeout, 0);
    chk("G_err_overrun", err_overrun, 0);
    tick();
    en = 1'b0;
    rst = 1'b0;
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
